mod_exp_ctrl: RTL

- Modular-exponentiation sequencer for the RSA datapath: result = m^e mod n.
- Sits directly upstream of the Montgomery multiplier and drives it as a modular-multiply engine. The multiplier does its own domain conversion, so each job returns a*b mod n.
- Uses left-to-right binary square-and-multiply and issues one multiplier job per square or multiply step.
- Exponent leading zeros are skipped; the first set bit loads the accumulator with m directly.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/mod_exp_ctrl_if.sv | 19 +
 rtl/mod_exp_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and defaults for the RSA modular-exponentiation datapath
package rsa_pkg;
    localparam int RSA_WIDTH = 2048;
    typedef enum logic [3:0] {
        ME_IDLE,
        ME_SCAN,
        ME_SQR,
        ME_SQR_W,
        ME_MUL,
        ME_MUL_W,
        ME_NEXT,
        ME_DONE,
        ME_ERR
    } me_state_t;
endpackage

// File: rtl/mod_exp_ctrl_if.sv
// mod_exp_ctrl_if: job bus between the exponentiation sequencer and the modular multiplier
interface mod_exp_ctrl_if import rsa_pkg::*; #(
    parameter int WIDTH = RSA_WIDTH
) ();
    logic [WIDTH-1:0] mm_x;
    logic [WIDTH-1:0] mm_y;
    logic [WIDTH-1:0] mm_n;
    logic             mm_start;
    logic             mm_finish;
    logic [WIDTH-1:0] mm_result;
    modport master (
        output mm_x, mm_y, mm_n, mm_start,
        input  mm_finish, mm_result
    );
    modport slave (
        input  mm_x, mm_y, mm_n, mm_start,
        output mm_finish, mm_result
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer computing m^e mod n on an external modmul engine
module mod_exp_ctrl import rsa_pkg::*; #(
    parameter int WIDTH = RSA_WIDTH,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             me_rst_n,
    input  logic             me_start,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             me_busy,
    output logic             me_finish,
    output logic             me_err,
    mod_exp_ctrl_if.master   mm
);
    me_state_t        state, state_d;
    logic [WIDTH-1:0] m_reg, e_reg, n_reg, acc;
    logic [IDXW-1:0]  idx;
    logic             bad, last, bit_set, sqr_phase, mul_phase;

    assign bad       = ~n[0] | (n == WIDTH'(1)) | (m >= n);
    assign last      = idx == '0;
    assign bit_set   = e_reg[idx];
    assign sqr_phase = state inside {ME_SQR, ME_SQR_W};
    assign mul_phase = state inside {ME_MUL, ME_MUL_W};

    assign me_busy     = state inside {ME_SCAN, ME_SQR, ME_SQR_W, ME_MUL, ME_MUL_W, ME_NEXT};
    assign mm.mm_start = state inside {ME_SQR, ME_MUL};
    assign mm.mm_x     = (sqr_phase | mul_phase) ? acc : '0;
    assign mm.mm_y     = sqr_phase ? acc : mul_phase ? m_reg : '0;
    assign mm.mm_n     = n_reg;

    // state register; reset aborts any job in flight
    always_ff @(posedge clk or negedge me_rst_n) begin
        if (!me_rst_n) state <= ME_IDLE;
        else           state <= state_d;
    end

    // next state: skip leading zeros, then one square (plus multiply on a set bit) per exponent bit
    always_comb begin
        state_d = state;
        case (state)
            ME_IDLE:  if (me_start) state_d = bad ? ME_ERR : ME_SCAN;
            ME_SCAN:  state_d = last ? ME_DONE : bit_set ? ME_SQR : ME_SCAN;
            ME_SQR:   state_d = ME_SQR_W;
            ME_SQR_W: if (mm.mm_finish) state_d = bit_set ? ME_MUL : ME_NEXT;
            ME_MUL:   state_d = ME_MUL_W;
            ME_MUL_W: if (mm.mm_finish) state_d = ME_NEXT;
            ME_NEXT:  state_d = last ? ME_DONE : ME_SQR;
            default:  state_d = ME_IDLE;
        endcase
    end

    // operand latch, accumulator, bit index and sticky completion flags
    always_ff @(posedge clk or negedge me_rst_n) begin
        if (!me_rst_n) begin
            m_reg     <= '0;
            e_reg     <= '0;
            n_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            result    <= '0;
            me_finish <= 1'b0;
            me_err    <= 1'b0;
        end else begin
            case (state)
                ME_IDLE: if (me_start) begin
                    m_reg     <= m;
                    e_reg     <= e;
                    n_reg     <= n;
                    idx       <= IDXW'(WIDTH - 1);
                    me_finish <= 1'b0;
                    me_err    <= 1'b0;
                end
                ME_SCAN: begin
                    if (bit_set)   acc <= m_reg;
                    else if (last) acc <= WIDTH'(1);
                    if (!last)     idx <= idx - 1'b1;
                end
                ME_SQR_W, ME_MUL_W: if (mm.mm_finish) acc <= mm.mm_result;
                ME_NEXT: if (!last) idx <= idx - 1'b1;
                ME_DONE: begin
                    result    <= acc;
                    me_finish <= 1'b1;
                end
                ME_ERR: begin
                    result <= '0;
                    me_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
